fft8_frame_ctrl: RTL
====================

Name: fft8_frame_ctrl

Overview:
Frame sequencer for the 8-point FFT datapath. It collects 8 signed time-domain samples from a valid/ready input stream and holds them stable on the core input bus. It waits a fixed core latency, then captures the core's 8 complex results and streams them out one bin per beat. It owns all timing and handshaking so the FFT core can stay purely combinational or fixed-latency.

Parameters:
DW, 32, sample and result width in bits (signed, two's complement).
CORE_LAT, 1, cycles between the core input bus changing and the core outputs being valid; legal range 0..15.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort; discards the current frame
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
in_data  in  DW  time-domain sample f_n
core_x  out  8*DW  packed core inputs; slice n = f_n
core_re  in  8*DW  packed core real outputs; slice k = F_k real
core_im  in  8*DW  packed core imaginary outputs; slice k = F_k imag
out_valid  out  1  output bin valid
out_ready  in  1  downstream accepts bin
out_re  out  DW  real part of current bin
out_im  out  DW  imaginary part of current bin
out_idx  out  3  bin index k of the current beat
out_last  out  1  high on the 8th beat of a frame
busy  out  1  high in any state other than LOAD with count 0
frame_cnt  out  16  completed frames; wraps at 65535 to 0

Behaviour:
- Reset (rst=1, async) values: state=LOAD, sample count=0, core_x=0, result regs=0, in_ready=1, out_valid=0, out_re/out_im=0, out_idx=0, out_last=0, busy=0, frame_cnt=0. Reset mid-frame discards all data.
- States: LOAD, WAIT, UNLOAD.
- LOAD:
  - in_ready=1.
  - Each accept (in_valid & in_ready) writes in_data to slice cnt of core_x and increments cnt.
  - The accept with cnt=7 sets cnt to 0, loads the wait counter with CORE_LAT, and moves to WAIT.
- WAIT:
  - in_ready=0.
  - The counter decrements each cycle. When it is 0, the next edge captures all 16 core_re/core_im words into result regs and moves to UNLOAD.
  - With CORE_LAT=0, capture occurs on the first edge after entry (one cycle in WAIT).
  - With CORE_LAT=L, WAIT lasts L+1 cycles.
- UNLOAD:
  - out_valid=1. Beat j presents bin j (out_idx=j) from the captured regs. in_ready=0.
  - A beat advances only on out_valid & out_ready. Outputs are held stable while out_ready=0.
  - Beat 7 has out_last=1. Its transfer increments frame_cnt, returns to LOAD, and sets in_ready=1 on the next cycle (no same-cycle pass-through).
- Latency: the first bin is presented CORE_LAT+2 cycles after the edge accepting the 8th sample.
- core_x changes only in LOAD. It is held constant through WAIT and UNLOAD.
- flush:
  - Takes priority over all handshakes in the same cycle.
  - From any state: next state=LOAD, cnt=0, out_valid=0. The sample or bin offered that cycle is not consumed.
  - frame_cnt, core_x and result regs are unchanged.
- busy=1 when state≠LOAD or cnt≠0.
- No arithmetic on data; widths pass through unchanged. The controller neither scales nor saturates.

Optional Feature:
BITREV_ORDER_EN:
- Defined: UNLOAD presents bins in 3-bit bit-reversed order 0,4,2,6,1,5,3,7. out_idx carries the true bin index (bit-reversed beat number). out_last stays on beat 7 (bin 7).
- Undefined: natural order 0..7, out_idx = beat number.

Decomposition:
- Package fft8_pkg holds:
  - state enum (LOAD, WAIT, UNLOAD);
  - constant N_PTS=8 and LOG2_N=3;
  - a bitrev3 function;
  - pack/unpack helpers for the 8*DW buses.
- One natural sub-module, fft8_result_buf: 8-entry complex capture register with indexed read mux. The controller FSM, counters and handshake logic stay in the top.

Test Plan:
- Bench drives the core ports from a behavioural 8-point DFT model honouring CORE_LAT.
- Impulse: feed 1,0,0,0,0,0,0,0 with out_ready=1 and CORE_LAT=1. Expect 8 beats re=1, im=0, idx 0..7, out_last on idx 7. The first out_valid is 3 cycles after the 8th accept. frame_cnt=1.
- Constant: feed eight 1s. Expect bin0 re=8, all other bins re=0 and im=0. Repeat with eight -2s: bin0 re=-16.
- Backpressure: toggle in_valid randomly, hold out_ready=0 for 5 cycles on beat 3. Expect out_re/out_im/out_idx stable while stalled, in_ready=0 throughout WAIT/UNLOAD, no lost or duplicated bins.
- Flush after 5 samples, then feed a fresh impulse frame. Expect the output to match the impulse only and frame_cnt to increment by exactly 1.
- Async reset asserted mid-UNLOAD at beat 4 (not clock-aligned). Expect immediate out_valid=0, in_ready=1, frame_cnt=0, and a correct next frame afterwards.
- CORE_LAT=3 with BITREV_ORDER_EN defined, input 0,1,2,3,4,5,6,7:
  - out_idx sequence 0,4,2,6,1,5,3,7;
  - bin0 re=28, bin4 re=-4 im=0;
  - first bin 5 cycles after the 8th accept.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point FFT frame controller.
package fft8_pkg;

  localparam int N_PTS  = 8;
  localparam int LOG2_N = 3;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_WAIT,
    ST_UNLOAD
  } state_t;

  function automatic logic [LOG2_N-1:0] bitrev3(input logic [LOG2_N-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // LSB position of lane n in a packed N_PTS*dw bus; lane 0 sits at bit 0.
  function automatic int lane_lo(input int n, input int dw);
    return n * dw;
  endfunction

endpackage

// File: rtl/fft8_result_buf.sv
// Eight-entry complex capture register with an indexed read port.
module fft8_result_buf
  import fft8_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap,
  input  logic [N_PTS*DW-1:0]   re_bus,
  input  logic [N_PTS*DW-1:0]   im_bus,
  input  logic [LOG2_N-1:0]     rd_idx,
  output logic [DW-1:0]         rd_re,
  output logic [DW-1:0]         rd_im
);

  logic [DW-1:0] re_q [N_PTS];
  logic [DW-1:0] im_q [N_PTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_PTS; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else if (cap) begin
      for (int k = 0; k < N_PTS; k++) begin
        re_q[k] <= re_bus[lane_lo(k, DW) +: DW];
        im_q[k] <= im_bus[lane_lo(k, DW) +: DW];
      end
    end
  end

  assign rd_re = re_q[rd_idx];
  assign rd_im = im_q[rd_idx];

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point FFT core: load 8 samples, wait CORE_LAT, stream 8 bins.
// Optional BITREV_ORDER_EN presents bins in bit-reversed order.
module fft8_frame_ctrl
  import fft8_pkg::*;
#(
  parameter int DW       = 32,
  parameter int CORE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic [8*DW-1:0]   core_x,
  input  logic [8*DW-1:0]   core_re,
  input  logic [8*DW-1:0]   core_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_re,
  output logic [DW-1:0]     out_im,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  // Handshakes: a sample moves on in_valid & in_ready, a bin on out_valid & out_ready,
  // both at the rising edge; flush overrides both so nothing is consumed that cycle.

  state_t              state_q, state_d;
  logic [LOG2_N-1:0]   cnt_q;
  logic [LOG2_N-1:0]   beat_q;
  logic [3:0]          wcnt_q;
  logic [15:0]         frame_cnt_q;
  logic [8*DW-1:0]     core_x_q;
  logic [LOG2_N-1:0]   bin_idx;

  logic accept, last_sample, capture, xfer, last_beat;

  assign in_ready    = (state_q == ST_LOAD);
  assign out_valid   = (state_q == ST_UNLOAD);
  assign accept      = in_ready & in_valid & ~flush;
  assign last_sample = accept & (cnt_q == 3'd7);
  assign capture     = (state_q == ST_WAIT) & (wcnt_q == 4'd0) & ~flush;
  assign xfer        = out_valid & out_ready & ~flush;
  assign last_beat   = (beat_q == 3'd7);

`ifdef BITREV_ORDER_EN
  assign bin_idx = bitrev3(beat_q);
`else
  assign bin_idx = beat_q;
`endif

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:   if (last_sample)        state_d = ST_WAIT;
        ST_WAIT:   if (wcnt_q == 4'd0)     state_d = ST_UNLOAD;
        ST_UNLOAD: if (xfer && last_beat)  state_d = ST_LOAD;
        default:                           state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      beat_q      <= '0;
      wcnt_q      <= '0;
      frame_cnt_q <= '0;
      core_x_q    <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        cnt_q  <= '0;
        beat_q <= '0;
      end else begin
        if (accept) begin
          core_x_q[lane_lo(int'(cnt_q), DW) +: DW] <= in_data;
          cnt_q <= cnt_q + 3'd1;
        end
        if (last_sample) begin
          wcnt_q <= 4'(CORE_LAT);
        end else if (state_q == ST_WAIT && wcnt_q != 4'd0) begin
          wcnt_q <= wcnt_q - 4'd1;
        end
        if (xfer) begin
          beat_q <= beat_q + 3'd1;
          if (last_beat) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
      end
    end
  end

  fft8_result_buf #(.DW(DW)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .cap    (capture),
    .re_bus (core_re),
    .im_bus (core_im),
    .rd_idx (bin_idx),
    .rd_re  (out_re),
    .rd_im  (out_im)
  );

  assign core_x    = core_x_q;
  assign out_idx   = bin_idx;
  assign out_last  = out_valid & last_beat;
  assign busy      = (state_q != ST_LOAD) | (cnt_q != '0);
  assign frame_cnt = frame_cnt_q;

endmodule
